// File: rtl/sm_uart_tx.sv
// Byte-wide 8N1 UART transmitter with a small FIFO in front of a registered serial line.
// One FSM walks START/DATA/STOP bits, each CLK_DIV cycles long, and pops the FIFO at frame boundaries.
module sm_uart_tx #(
  parameter int unsigned CLK_DIV = 868,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned BW    = $clog2(CLK_DIV);
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       mem_q [DEPTH];

  logic full, empty, push, pop, bit_end;
  logic [7:0] head;

  assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign push     = tx_valid && !full;
  assign head     = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign bit_end  = (baud_q == BAUD_LAST);
  assign tx_ready = !full;
  assign tx       = tx_q;
  assign busy     = busy_q;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    baud_d  = (state_q == IDLE || bit_end) ? '0 : baud_q + BW'(1);
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          bit_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit so back-to-back frames have no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            bit_d   = '0;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    wr_ptr_d = wr_ptr_q + (FIFO_AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (FIFO_AW+1)'(pop);
    busy_d   = (state_d != IDLE) || (wr_ptr_d != rd_ptr_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= tx_data;
  end

endmodule

// File: tb/tb_sm_uart_tx.sv
// Directed bench for sm_uart_tx: a fast instance (CLK_DIV=4) for framing/FIFO cases
// and a CLK_DIV=868 instance decoded by a 115200-baud host receiver model.
module tb_sm_uart_tx;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_ready, s_tx, s_busy;

  always #5 clk = ~clk;

  sm_uart_tx #(.CLK_DIV(DIV), .FIFO_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy)
  );

  sm_uart_tx #(.CLK_DIV(868), .FIFO_AW(2)) dut_slow (
    .clk(clk), .rst_n(rst_n), .tx_data(s_data), .tx_valid(s_valid),
    .tx_ready(s_ready), .tx(s_tx), .busy(s_busy)
  );

  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line recorder for the fast instance, sampled mid-cycle.
  logic cap [0:1023];
  int   ncap = 0;
  logic rec = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rec && ncap < 1024) begin
      cap[ncap] = tx;
      ncap++;
    end
  end

  logic [7:0] fr_byte [16];
  int         fr_start [16];
  logic       fr_ok [16];
  int         nfr;

  // Frames must be exactly DIV samples per bit, start low, stop high.
  task automatic decode();
    int idx;
    idx = 0;
    nfr = 0;
    while (idx + 10*DIV <= ncap && nfr < 16) begin
      if (cap[idx] === 1'b0) begin
        logic [7:0] b;
        logic ok;
        logic lvl;
        b  = '0;
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
          lvl = cap[idx + k*DIV];
          for (int j = 1; j < DIV; j++)
            if (cap[idx + k*DIV + j] !== lvl) ok = 1'b0;
          if (k >= 1 && k <= 8) b[k-1] = lvl;
          if (k == 9 && lvl !== 1'b1) ok = 1'b0;
        end
        fr_byte[nfr]  = b;
        fr_start[nfr] = idx;
        fr_ok[nfr]    = ok;
        nfr++;
        idx += 10*DIV;
      end else begin
        idx++;
      end
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    s_valid  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic lbuf [0:8699];

  initial begin
    int acc, hi, zeros, bad;
    logic rdy;
    logic [7:0] host;

    do_reset();
    check("rst_tx", tx, 1'b1);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_slow_tx", s_tx, 1'b1);

    // Single byte 0xA5 into an idle block.
    ncap = 0; rec = 1'b1;
    tx_valid = 1'b1; tx_data = 8'hA5;
    tick();
    tx_valid = 1'b0; tx_data = 8'h3C;
    check("t1_tx_before_start", tx, 1'b1);
    check("t1_busy_on_accept", busy, 1'b1);
    repeat (40) tick();
    check("t1_busy_in_stop", busy, 1'b1);
    tick();
    check("t1_busy_after_stop", busy, 1'b0);
    check("t1_tx_idle", tx, 1'b1);
    repeat (4) tick();
    rec = 1'b0;
    decode();
    check("t1_nframes", nfr, 1);
    check("t1_byte", fr_byte[0], 8'hA5);
    check("t1_frame_ok", fr_ok[0], 1'b1);
    check("t1_latency_idx", fr_start[0], 2);

    // Five bytes with tx_valid held, then garbage offered while full.
    ncap = 0; rec = 1'b1;
    acc = 0;
    tx_valid = 1'b1; tx_data = 8'h01;
    for (int i = 0; i < 10 && acc < 5; i++) begin
      rdy = tx_ready;
      tick();
      if (rdy) begin
        acc++;
        tx_data = 8'(acc + 1);
      end
    end
    check("t2_accepted", acc, 5);
    check("t2_full_ready_low", tx_ready, 1'b0);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      tx_data = 8'hC0 + 8'(i);
      tx_valid = 1'b1;
      if (tx_ready) hi++;
      tick();
    end
    tx_valid = 1'b0;
    check("t3_ready_while_full", hi, 0);
    repeat (190) tick();
    check("t2_busy_done", busy, 1'b0);
    rec = 1'b0;
    decode();
    check("t2_nframes", nfr, 5);
    bad = 0;
    for (int i = 0; i < 5 && i < nfr; i++) begin
      if (fr_byte[i] !== 8'(i + 1)) bad++;
      if (fr_ok[i] !== 1'b1) bad++;
      if (fr_start[i] - fr_start[0] != 40*i) bad++;
    end
    check("t2_frames_content_spacing", bad, 0);
    check("t2_first_start", fr_start[0], 2);

    // 0x00 then 0xFF.
    ncap = 0; rec = 1'b1;
    tx_valid = 1'b1; tx_data = 8'h00;
    tick();
    tx_data = 8'hFF;
    tick();
    tx_valid = 1'b0;
    repeat (90) tick();
    rec = 1'b0;
    decode();
    check("t4_nframes", nfr, 2);
    check("t4_byte0", fr_byte[0], 8'h00);
    check("t4_byte1", fr_byte[1], 8'hFF);
    check("t4_ok", {fr_ok[0], fr_ok[1]}, 2'b11);
    zeros = 0;
    for (int i = fr_start[0]; i < ncap && cap[i] === 1'b0; i++) zeros++;
    check("t4_low_run", zeros, 9*DIV);
    check("t4_spacing", fr_start[1] - fr_start[0], 10*DIV);

    // Reset in cycle 13 of a frame with a second byte still queued.
    tx_valid = 1'b1; tx_data = 8'h00;
    tick();
    tick();
    tx_valid = 1'b0;
    repeat (12) tick();
    check("t5_pre_tx_low", tx, 1'b0);
    check("t5_pre_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_tx", tx, 1'b1);
    check("t5_async_busy", busy, 1'b0);
    check("t5_async_ready", tx_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ncap = 0; rec = 1'b1;
    repeat (60) tick();
    rec = 1'b0;
    zeros = 0;
    for (int i = 0; i < ncap; i++) if (cap[i] !== 1'b1) zeros++;
    check("t5_no_residual", zeros, 0);
    check("t5_busy_after", busy, 1'b0);

    // 0x55 at CLK_DIV=868 through a 115200-baud host receiver.
    s_valid = 1'b1; s_data = 8'h55;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 8700; i++) begin
      tick();
      lbuf[i] = s_tx;
    end
    check("t6_start_edge", lbuf[0], 1'b0);
    acc = 0; bad = 0;
    for (int i = 1; i < 8700; i++) begin
      if (lbuf[i] !== lbuf[i-1]) begin
        acc++;
        if (i % 868 != 0) bad++;
      end
    end
    check("t6_transitions", acc, 9);
    check("t6_bit_width", bad, 0);
    host = '0;
    for (int b = 0; b < 8; b++) host[b] = lbuf[$rtoi((real'(b) + 1.5) * 868.0555)];
    check("t6_host_byte", host, 8'h55);
    check("t6_host_stop", lbuf[$rtoi(9.5 * 868.0555)], 1'b1);
    check("t6_busy_done", s_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
